mmm_result_packer: RTL

MMM_RESULT_PACKER -- requirements
Module: mmm_result_packer

---
 rtl/mmm_pkg.sv | 20 ++
 rtl/mmm_result_ram.sv | 31 +++
 rtl/mmm_result_packer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mmm_pkg.sv
// Shared widths, the packer state type and a saturating counter helper
// for the maximum-clique result packer.
package mmm_pkg;

    localparam int VTX_W  = 12;
    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int PAD_W  = HALF_W - VTX_W;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HEADER  = 2'd1,
        ST_DATA    = 2'd2
    } pack_state_e;

    function automatic logic [HALF_W-1:0] sat_inc16(input logic [HALF_W-1:0] v);
        return (v == '1) ? v : v + HALF_W'(1);
    endfunction

endpackage

// File: rtl/mmm_result_ram.sv
// Simple dual-port vertex-id storage: one write port and one read port
// with a registered read data output.
module mmm_result_ram
    import mmm_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [VTX_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [VTX_W-1:0]  rdata_o
);

    logic [VTX_W-1:0] mem_q [DEPTH];
    logic [VTX_W-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto block RAM;
    // stale contents are never observed because reads are bounded by wr_cnt.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mmm_result_packer.sv
// Collects clique vertex ids from the solver core and streams a header word
// plus packed vertex-pair words to the host. DEPTH: power of two, >= 4.
module mmm_result_packer
    import mmm_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic              i_clk50,
    input  logic              i_reset,
    input  logic [VTX_W-1:0]  i_vtx,
    input  logic              i_vtx_valid,
    input  logic              i_clique_end,
    input  logic              i_flush,
    input  logic              i_done,
    input  logic [HALF_W-1:0] i_maxsize,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_outdata,
    output logic              o_outdata_ready,
    input  logic              i_outdata_want,
    output logic              o_overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int BAW   = AW - 1;

    pack_state_e       state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [HALF_W-1:0] n_cliques_q, n_cliques_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              out_ready_q, out_ready_d;
    logic              overflow_q, overflow_d;

    logic [CNT_W-1:0]  wr_base;
    logic [HALF_W-1:0] ncl_base;
    logic              wr_en;
    logic [CNT_W-1:0]  n_words;
    logic              xfer;
    logic              last_word;
    logic              load;
    logic              odd_present;
    logic [BAW-1:0]    rd_addr;
    logic [VTX_W-1:0]  even_rdata;
    logic [VTX_W-1:0]  odd_rdata;

    // Even/odd banks let one cycle fetch both halves of a data word.
    mmm_result_ram #(.DEPTH(DEPTH / 2)) u_ram_even (
        .clk_i   (i_clk50),
        .we_i    (wr_en & ~wr_base[0]),
        .waddr_i (wr_base[AW-1:1]),
        .wdata_i (i_vtx),
        .raddr_i (rd_addr),
        .rdata_o (even_rdata)
    );

    mmm_result_ram #(.DEPTH(DEPTH / 2)) u_ram_odd (
        .clk_i   (i_clk50),
        .we_i    (wr_en & wr_base[0]),
        .waddr_i (wr_base[AW-1:1]),
        .wdata_i (i_vtx),
        .raddr_i (rd_addr),
        .rdata_o (odd_rdata)
    );

    assign n_words     = (wr_cnt_q + CNT_W'(1)) >> 1;
    assign xfer        = out_ready_q && i_outdata_want;
    assign last_word   = ({1'b0, rd_ptr_q} == n_words);
    assign load        = (state_q == ST_DATA) && (!out_ready_q || i_outdata_want) && !last_word;
    assign odd_present = ({rd_ptr_q, 1'b1} < wr_cnt_q);
    // The read port always presents the word that the next load will consume.
    assign rd_addr     = rd_ptr_q[BAW-1:0] + BAW'(load);
    assign wr_base     = i_flush ? '0 : wr_cnt_q;
    assign ncl_base    = i_flush ? '0 : n_cliques_q;

    // NOTE: every next-state signal takes its current value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        n_cliques_d = n_cliques_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_ready_d = out_ready_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                wr_cnt_d    = wr_base;
                n_cliques_d = ncl_base;
                if (i_vtx_valid) begin
                    // wr_base tops out at DEPTH, so its MSB alone flags a full buffer.
                    if (!wr_base[AW]) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_base + CNT_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (i_clique_end) begin
                    n_cliques_d = sat_inc16(ncl_base);
                end
                if (i_done) begin
                    // The header register doubles as the latched maxsize.
                    out_data_d  = {i_maxsize, n_cliques_d};
                    out_ready_d = 1'b1;
                    state_d     = ST_HEADER;
                end
            end

            ST_HEADER: begin
                if (xfer) begin
                    out_ready_d = 1'b0;
                    if (wr_cnt_q == '0) begin
                        n_cliques_d = '0;
                        state_d     = ST_COLLECT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (load) begin
                    out_data_d  = {(odd_present ? {{PAD_W{1'b0}}, odd_rdata} : {HALF_W{1'b0}}),
                                   {PAD_W{1'b0}}, even_rdata};
                    out_ready_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                end else if (xfer) begin
                    out_ready_d = 1'b0;
                    wr_cnt_d    = '0;
                    n_cliques_d = '0;
                    rd_ptr_d    = '0;
                    state_d     = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk50 or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_COLLECT;
            wr_cnt_q    <= '0;
            n_cliques_q <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_ready_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            n_cliques_q <= n_cliques_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_ready_q <= out_ready_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_busy          = (state_q != ST_COLLECT);
    assign o_outdata       = out_data_q;
    assign o_outdata_ready = out_ready_q;
    assign o_overflow      = overflow_q;

endmodule
